// File: rtl/picorv32_pcpi_hub_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : picorv32_pcpi_hub_if
// Description : PCPI bundle. It carries the core-side port and the
//               co-processor fan-out of the PCPI hub.
// Revision    : 1.0 - initial release
// ============================================================================
interface picorv32_pcpi_hub_if #(
  parameter int NCOP = 2
);
  // Core side
  logic                 pcpi_valid;
  logic [31:0]          pcpi_insn;
  logic [31:0]          pcpi_rs1;
  logic [31:0]          pcpi_rs2;
  logic                 pcpi_wr;
  logic [31:0]          pcpi_rd;
  logic                 pcpi_wait;
  logic                 pcpi_ready;
  logic                 pcpi_timeout;
  // Co-processor side; cop_rd slice i is [32*i+31:32*i]
  logic [NCOP-1:0]      cop_valid;
  logic [31:0]          cop_insn;
  logic [31:0]          cop_rs1;
  logic [31:0]          cop_rs2;
  logic [NCOP-1:0]      cop_wr;
  logic [NCOP*32-1:0]   cop_rd;
  logic [NCOP-1:0]      cop_wait;
  logic [NCOP-1:0]      cop_ready;

  // Hub view
  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    output cop_valid, cop_insn, cop_rs1, cop_rs2,
    input  cop_wr, cop_rd, cop_wait, cop_ready
  );

  // Environment view: core plus co-processors
  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    input  cop_valid, cop_insn, cop_rs1, cop_rs2,
    output cop_wr, cop_rd, cop_wait, cop_ready
  );
endinterface
`default_nettype wire

// File: rtl/picorv32_pcpi_hub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : picorv32_pcpi_hub
// Description : PCPI dispatcher. It registers and broadcasts one instruction
//               to NCOP co-processors and returns the lowest-index ready
//               result. It pulses pcpi_timeout when no co-processor claims
//               the instruction within TIMEOUT busy cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_pcpi_hub #(
  parameter int NCOP    = 2,   // 1..8, must match the interface
  parameter int TIMEOUT = 16   // 2..255
) (
  input  wire logic            clk,
  input  wire logic            resetn,
  picorv32_pcpi_hub_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q,   state_d;
  logic        valid_q,   valid_d;
  logic [31:0] insn_q,    insn_d;
  logic [31:0] rs1_q,     rs1_d;
  logic [31:0] rs2_q,     rs2_d;
  logic        wr_q,      wr_d;
  logic [31:0] rd_q,      rd_d;
  logic        wait_q,    wait_d;
  logic        ready_q,   ready_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic        claimed_q, claimed_d;

  logic        sel_wr;
  logic [31:0] sel_rd;

  // Lowest-index ready co-processor wins; the others are ignored.
  always_comb begin
    sel_wr = 1'b0;
    sel_rd = 32'd0;
    for (int i = NCOP - 1; i >= 0; i--) begin
      if (bus.cop_ready[i]) begin
        sel_wr = bus.cop_wr[i];
        sel_rd = bus.cop_rd[32*i +: 32];
      end
    end
  end

  // Next-state and registered-output logic for the dispatch FSM.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    insn_d    = insn_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    wr_d      = 1'b0;
    rd_d      = rd_q;
    wait_d    = wait_q;
    ready_d   = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    claimed_d = claimed_q;
    case (state_q)
      IDLE: begin
        wait_d = 1'b0;
        if (bus.pcpi_valid) begin
          insn_d    = bus.pcpi_insn;
          rs1_d     = bus.pcpi_rs1;
          rs2_d     = bus.pcpi_rs2;
          valid_d   = 1'b1;
          cnt_d     = 8'd0;
          claimed_d = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (!bus.pcpi_valid) begin
          // Core abandoned the instruction: no completion is reported.
          valid_d = 1'b0;
          wait_d  = 1'b0;
          state_d = IDLE;
        end else if (|bus.cop_ready) begin
          // Ready beats a timeout that would expire on the same edge.
          ready_d = 1'b1;
          wr_d    = sel_wr;
          rd_d    = sel_rd;
          wait_d  = 1'b0;
          valid_d = 1'b0;
          state_d = DONE;
        end else begin
          wait_d    = |bus.cop_wait;
          claimed_d = claimed_q | (|bus.cop_wait);
          if (!claimed_d) begin
            if (cnt_q == TIMEOUT_C) begin
              timeout_d = 1'b1;
              wait_d    = 1'b0;
              valid_d   = 1'b0;
              state_d   = DONE;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      end
      DONE: begin
        // A still-high pcpi_valid belongs to the finished op.
        wait_d = 1'b0;
        if (!bus.pcpi_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        wait_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      insn_q    <= 32'd0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      wr_q      <= 1'b0;
      rd_q      <= 32'd0;
      wait_q    <= 1'b0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 8'd0;
      claimed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      insn_q    <= insn_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      wait_q    <= wait_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      claimed_q <= claimed_d;
    end
  end

  assign bus.cop_valid    = {NCOP{valid_q}};
  assign bus.cop_insn     = insn_q;
  assign bus.cop_rs1      = rs1_q;
  assign bus.cop_rs2      = rs2_q;
  assign bus.pcpi_wr      = wr_q;
  assign bus.pcpi_rd      = rd_q;
  assign bus.pcpi_wait    = wait_q;
  assign bus.pcpi_ready   = ready_q;
  assign bus.pcpi_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_pcpi_hub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_picorv32_pcpi_hub
// Description : Self-checking bench for picorv32_pcpi_hub with a response
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_pcpi_hub;

  localparam int NCOP    = 2;
  localparam int TIMEOUT = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  picorv32_pcpi_hub_if #(.NCOP(NCOP)) bus();

  picorv32_pcpi_hub #(.NCOP(NCOP), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic        is_to;
    logic        wr;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = 32'd0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every completion or timeout pulse pops one expectation.
  always @(negedge clk) begin
    if (resetn && (bus.pcpi_ready || bus.pcpi_timeout)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", {30'd0, bus.pcpi_ready, bus.pcpi_timeout}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("resp_kind", {30'd0, bus.pcpi_ready, bus.pcpi_timeout}, e.is_to ? 32'd1 : 32'd2);
        check_eq("resp_wr",   {31'd0, bus.pcpi_wr}, {31'd0, e.wr});
        check_eq("resp_rd",   bus.pcpi_rd, e.rd);
      end
    end
  end

  task automatic drive_idle();
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = 32'd0;
    bus.pcpi_rs1   = 32'd0;
    bus.pcpi_rs2   = 32'd0;
    bus.cop_wr     = '0;
    bus.cop_rd     = '0;
    bus.cop_wait   = '0;
    bus.cop_ready  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction. k counts cycles since cop_valid rose; co-processors
  // assert wait from k=wait_from and ready for the single cycle k=ready_at.
  task automatic do_op(input string name, input logic [31:0] insn,
                       input logic [1:0] rmask, input int ready_at,
                       input logic [1:0] wmask, input int wait_from,
                       input logic [1:0] wrs, input logic [31:0] rd0,
                       input logic [31:0] rd1, input int hold);
    exp_t e;
    int   k;
    int   exp_lat;
    bit   done;
    bit   wait_ok;
    bit   hold_ok;
    if (rmask[0])      e = '{is_to: 1'b0, wr: wrs[0], rd: rd0};
    else if (rmask[1]) e = '{is_to: 1'b0, wr: wrs[1], rd: rd1};
    else               e = '{is_to: 1'b1, wr: 1'b0,   rd: last_rd};
    last_rd = e.rd;
    sb.push_back(e);
    exp_lat = (rmask != 2'b00) ? ready_at + 1 : TIMEOUT + 1;

    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = insn ^ 32'hA5A5_A5A5;
    bus.pcpi_rs2   = ~insn;
    bus.cop_rd     = {rd1, rd0};
    bus.cop_wr     = wrs;
    tick();
    check_eq({name, "_cop_valid"}, {30'd0, bus.cop_valid}, 32'd3);
    check_eq({name, "_cop_insn"},  bus.cop_insn, insn);
    check_eq({name, "_cop_rs1"},   bus.cop_rs1, insn ^ 32'hA5A5_A5A5);

    k = 0; done = 0; wait_ok = 1;
    while (!done && k < 200) begin
      bus.cop_wait  = (k >= wait_from) ? wmask : 2'b00;
      bus.cop_ready = (k == ready_at)  ? rmask : 2'b00;
      tick();
      k++;
      if (bus.pcpi_ready || bus.pcpi_timeout) done = 1;
      else if (wmask != 2'b00 && k > wait_from && bus.pcpi_wait !== 1'b1) wait_ok = 0;
    end
    bus.cop_wait  = 2'b00;
    bus.cop_ready = 2'b00;
    check_eq({name, "_latency"},   k, exp_lat);
    check_eq({name, "_valid_off"}, {30'd0, bus.cop_valid}, 32'd0);
    check_eq({name, "_wait_off"},  {31'd0, bus.pcpi_wait}, 32'd0);
    if (wmask != 2'b00) check_eq({name, "_wait_held"}, {31'd0, wait_ok}, 32'd1);

    // Pulse lasts one cycle; a held pcpi_valid must not re-dispatch.
    hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.cop_valid != 2'b00 || bus.pcpi_ready || bus.pcpi_timeout) hold_ok = 0;
    end
    bus.pcpi_valid = 1'b0;
    tick();
    if (bus.pcpi_ready || bus.pcpi_timeout || bus.cop_valid != 2'b00) hold_ok = 0;
    check_eq({name, "_done_quiet"}, {31'd0, hold_ok}, 32'd1);
    check_eq({name, "_rd_hold"}, bus.pcpi_rd, last_rd);
  endtask

  initial begin
    drive_idle();
    resetn = 1'b0;
    repeat (3) tick();
    check_eq("rst_cop_valid", {30'd0, bus.cop_valid}, 32'd0);
    check_eq("rst_flags", {28'd0, bus.pcpi_ready, bus.pcpi_wr, bus.pcpi_wait, bus.pcpi_timeout}, 32'd0);
    check_eq("rst_rd", bus.pcpi_rd, 32'd0);
    resetn = 1'b1;
    tick();

    do_op("mul_basic", 32'h0200_0033, 2'b01, 3,  2'b00, 1000, 2'b11, 32'h0000_0F0F, 32'h0, 3);
    do_op("div_long",  32'h0200_4033, 2'b10, 40, 2'b10, 2,    2'b11, 32'h0, 32'hFFFF_FFFD, 0);
    do_op("unclaimed", 32'h0000_0073, 2'b00, -1, 2'b00, 1000, 2'b11, 32'hDEAD_0001, 32'hDEAD_0002, 0);
    do_op("both_rdy",  32'h0200_0033, 2'b11, 2,  2'b00, 1000, 2'b11, 32'h0000_0011, 32'h0000_0022, 0);
    do_op("no_write",  32'h0200_5033, 2'b10, 0,  2'b00, 1000, 2'b00, 32'h0, 32'h1234_5678, 0);
    do_op("rdy_at_to", 32'h0200_1033, 2'b01, TIMEOUT, 2'b00, 1000, 2'b01, 32'hCAFE_0001, 32'h0, 1);
    do_op("late_claim", 32'h0200_6033, 2'b10, 30, 2'b10, TIMEOUT - 1, 2'b10, 32'h0, 32'h7777_0000, 0);

    // Core abort: drop pcpi_valid while BUSY; no pulse may follow.
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = 32'h0200_7033;
    bus.cop_wait   = 2'b01;
    tick();
    tick();
    bus.pcpi_valid = 1'b0;
    tick();
    check_eq("abort_valid", {30'd0, bus.cop_valid}, 32'd0);
    check_eq("abort_wait",  {31'd0, bus.pcpi_wait}, 32'd0);
    // Stray ready while idle is ignored.
    bus.cop_ready = 2'b11;
    bus.cop_rd    = {32'hBAD0_0002, 32'hBAD0_0001};
    repeat (3) tick();
    bus.cop_ready = 2'b00;
    bus.cop_wait  = 2'b00;
    check_eq("stray_rd", bus.pcpi_rd, last_rd);

    // Asynchronous reset in the middle of a claimed op.
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = 32'h0200_0033;
    bus.cop_wait   = 2'b01;
    repeat (6) tick();
    check_eq("pre_rst_wait", {31'd0, bus.pcpi_wait}, 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("arst_cop", {30'd0, bus.cop_valid}, 32'd0);
    check_eq("arst_flags", {31'd0, bus.pcpi_wait}, 32'd0);
    check_eq("arst_rd", bus.pcpi_rd, 32'd0);
    check_eq("arst_insn", bus.cop_insn, 32'd0);
    last_rd = 32'd0;
    drive_idle();
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    do_op("post_rst", 32'h0200_0033, 2'b01, 1, 2'b00, 1000, 2'b01, 32'h5555_AAAA, 32'h0, 0);

    repeat (3) tick();
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
